// File: rtl/synth_result_collector.sv
// Capture stage for a synth_core result stream: show-ahead FIFO toward the
// consumer, plus a MISR signature, sample counter and sticky drop flag.
module synth_result_collector #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter int          CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              in_result,
  input  logic                     in_valid,
  input  logic                     sig_clear,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              signature,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [31:0]      sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic        full;
  logic        push;
  logic        pop;
  logic        drop;
  logic [31:0] sig_next;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a sample when the head leaves the same cycle.
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;
  assign sig_next  = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ in_result;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Clear wins over the same-cycle sample; the FIFO path is unaffected.
    if (sig_clear) begin
      sig_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (in_valid) begin
      sig_d = sig_next;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (drop)        ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sig_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_result;
  end

  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign level     = level_q;
  assign signature = sig_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;

endmodule
